logic_analyzer: RTL and testbench



---
 rtl/logic_analyzer.sv | 240 ++++++++++++++++++++++++
 tb/tb_logic_analyzer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_analyzer.sv
// logic_analyzer: 3-channel logic analyzer. It run-length encodes the synchronized
// probe inputs into 8-bit records {value[2:0], count[4:0]} and stores them in a
// DEPTH-entry buffer. When the buffer is full it dumps the buffer as 8N1 UART frames.
// Optional build macro: LA_TX_HEADER_EN prefixes each dump with 0xA5, DEPTH[7:0].
module logic_analyzer #(
   parameter int unsigned BAUD_DIV   = 87,
   parameter int unsigned SAMPLE_DIV = 1,
   parameter int unsigned DEPTH      = 16
) (
   input  logic       inclk0_10MHz,
   input  logic       rst,
   input  logic [2:0] dataIn,
   output logic       TxD,
   output logic [4:0] state_debug,
   output logic [7:0] dataOut_debug
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned PW = AW + 1;
   localparam int unsigned BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
   localparam int unsigned SW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
`ifdef LA_TX_HEADER_EN
   localparam int unsigned NHDR = 2;
`else
   localparam int unsigned NHDR = 0;
`endif
   localparam int unsigned NBYTES = DEPTH + NHDR;
   localparam int unsigned IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam logic [4:0]  RUN_MAX = 5'd31;

   typedef enum logic [4:0] {
      IDLE     = 5'd0,
      CAPTURE  = 5'd1,
      TX_LOAD  = 5'd2,
      TX_START = 5'd3,
      TX_DATA  = 5'd4,
      TX_STOP  = 5'd5
   } state_t;

   state_t          state;
   state_t          state_nxt;

   logic [2:0]      sync1;
   logic [2:0]      s;
   logic [SW-1:0]   presc;
   logic            tick;

   logic [2:0]      baseline;
   logic [2:0]      run_val;
   logic [4:0]      run_cnt;
   logic [PW-1:0]   wr_ptr;
   logic [7:0]      mem [DEPTH];

   logic [IW-1:0]   tx_idx;
   logic [BW-1:0]   baud_cnt;
   logic [2:0]      bit_cnt;
   logic [7:0]      shifter;

   logic            emit;
   logic            cap_full;
   logic            baud_done;
   logic            last_byte;

   logic            trig;
   logic            buf_we;
   logic            load_en;
   logic            dump_done;
   logic [IW-1:0]   load_idx;
   logic [7:0]      load_byte;

   // Shared status terms used by both the next-state and output logic
   assign tick      = (presc == SW'(SAMPLE_DIV - 1));
   assign emit      = (s != run_val) || (run_cnt == RUN_MAX);
   assign cap_full  = (wr_ptr == PW'(DEPTH - 1));
   assign baud_done = (baud_cnt == BW'(BAUD_DIV - 1));
   assign last_byte = (tx_idx == IW'(NBYTES - 1));

   assign state_debug = state;

   // State register; reset aborts any capture or frame immediately
   always_ff @(posedge inclk0_10MHz or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic; unused codes fall back to IDLE
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:     if (tick && (s != baseline)) state_nxt = CAPTURE;
         CAPTURE:  if (tick && emit && cap_full) state_nxt = TX_LOAD;
         TX_LOAD:  state_nxt = TX_START;
         TX_START: if (baud_done) state_nxt = TX_DATA;
         TX_DATA:  if (baud_done && (bit_cnt == 3'd7)) state_nxt = TX_STOP;
         TX_STOP:  if (baud_done) state_nxt = last_byte ? IDLE : TX_LOAD;
         default:  state_nxt = IDLE;
      endcase
   end

   // Control decode: capture strobes and selection of the next byte to transmit
   always_comb begin
      trig      = 1'b0;
      buf_we    = 1'b0;
      load_en   = 1'b0;
      dump_done = 1'b0;
      load_idx  = '0;
      load_byte = 8'h00;

      trig      = (state == IDLE) && tick && (s != baseline);
      buf_we    = (state == CAPTURE) && tick && emit;
      load_en   = (state_nxt == TX_LOAD);
      dump_done = (state == TX_STOP) && baud_done && last_byte;
      // Entering TX_LOAD from CAPTURE starts at byte 0, from TX_STOP at the next byte
      load_idx  = (state == TX_STOP) ? IW'(tx_idx + 1'b1) : '0;
`ifdef LA_TX_HEADER_EN
      if (load_idx == '0) begin
         load_byte = 8'hA5;
      end else if (load_idx == IW'(1)) begin
         load_byte = 8'(DEPTH);
      end else begin
         load_byte = mem[AW'(load_idx - IW'(2))];
      end
`else
      load_byte = mem[AW'(load_idx)];
`endif
   end

   // Two-flop input synchronizer and free-running sample prescaler
   always_ff @(posedge inclk0_10MHz or posedge rst) begin
      if (rst) begin
         sync1 <= 3'b000;
         s     <= 3'b000;
         presc <= '0;
      end else begin
         sync1 <= dataIn;
         s     <= sync1;
         presc <= tick ? '0 : presc + 1'b1;
      end
   end

   // Trigger baseline, run-length counter and buffer write pointer
   always_ff @(posedge inclk0_10MHz or posedge rst) begin
      if (rst) begin
         baseline <= 3'b000;
         run_val  <= 3'b000;
         run_cnt  <= 5'd0;
         wr_ptr   <= '0;
      end else begin
         if ((state == IDLE) && tick) begin
            baseline <= s;
         end
         if (trig) begin
            run_val <= s;
            run_cnt <= 5'd1;
         end else if ((state == CAPTURE) && tick) begin
            if (emit) begin
               run_val <= s;
               run_cnt <= 5'd1;
               wr_ptr  <= wr_ptr + 1'b1;
            end else begin
               run_cnt <= run_cnt + 5'd1;
            end
         end
         if (dump_done) begin
            wr_ptr   <= '0;
            baseline <= s;
         end
      end
   end

   // Record buffer; contents need no reset since wr_ptr gates what is valid
   always_ff @(posedge inclk0_10MHz) begin
      if (buf_we) begin
         mem[wr_ptr[AW-1:0]] <= {run_val, run_cnt};
      end
   end

   // UART shifter: TxD is registered and changes on the same edge as the state
   always_ff @(posedge inclk0_10MHz or posedge rst) begin
      if (rst) begin
         TxD           <= 1'b1;
         shifter       <= 8'h00;
         dataOut_debug <= 8'h00;
         tx_idx        <= '0;
         baud_cnt      <= '0;
         bit_cnt       <= 3'd0;
      end else begin
         if (load_en) begin
            shifter       <= load_byte;
            dataOut_debug <= load_byte;
            tx_idx        <= load_idx;
         end
         case (state)
            TX_LOAD: begin
               TxD      <= 1'b0;
               baud_cnt <= '0;
            end
            TX_START: begin
               if (baud_done) begin
                  TxD      <= shifter[0];
                  baud_cnt <= '0;
                  bit_cnt  <= 3'd0;
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            TX_DATA: begin
               if (baud_done) begin
                  baud_cnt <= '0;
                  if (bit_cnt == 3'd7) begin
                     TxD <= 1'b1;
                  end else begin
                     TxD     <= shifter[1];
                     shifter <= {1'b0, shifter[7:1]};
                     bit_cnt <= bit_cnt + 3'd1;
                  end
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            TX_STOP: begin
               TxD <= 1'b1;
               if (baud_done) begin
                  baud_cnt <= '0;
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            default: begin
               TxD      <= 1'b1;
               baud_cnt <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_logic_analyzer.sv
// tb_logic_analyzer: directed and randomized checks of capture, RLE records and UART dump.
`timescale 1ns/1ps
module tb_logic_analyzer;

   localparam int unsigned BAUD_DIV   = 4;
   localparam int unsigned SAMPLE_DIV = 1;
   localparam int unsigned DEPTH      = 4;
`ifdef LA_TX_HEADER_EN
   localparam int NHDR = 2;
`else
   localparam int NHDR = 0;
`endif
   localparam int NBYTES    = int'(DEPTH) + NHDR;
   localparam int CYC_LIMIT = 3000;
   localparam int FRAME_GAP = 10 * int'(BAUD_DIV) + 1;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] dataIn;
   logic       TxD;
   logic [4:0] state_debug;
   logic [7:0] dataOut_debug;

   int         tests = 0;
   int         fails = 0;
   int         cyc   = 0;
   logic [2:0] stim_q [$];
   logic [7:0] exp_q  [$];
   logic [7:0] rx_q   [$];
   logic [2:0] base;

   logic_analyzer #(
      .BAUD_DIV   (BAUD_DIV),
      .SAMPLE_DIV (SAMPLE_DIV),
      .DEPTH      (DEPTH)
   ) dut (
      .inclk0_10MHz  (clk),
      .rst           (rst),
      .dataIn        (dataIn),
      .TxD           (TxD),
      .state_debug   (state_debug),
      .dataOut_debug (dataOut_debug)
   );

   always #50 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Expected dump: split the sample stream into maximal equal-value runs starting at
   // the first change from the idle baseline, chop each run into pieces of at most 31.
   task automatic model(output int trig_at);
      logic [2:0] v [$];
      int j, len, piece;
      v = stim_q;
      for (int k = 0; k < 300; k++) v.push_back(stim_q[stim_q.size()-1]);
      exp_q.delete();
`ifdef LA_TX_HEADER_EN
      exp_q.push_back(8'hA5);
      exp_q.push_back(8'(DEPTH));
`endif
      trig_at = -1;
      for (int i = 0; i < v.size(); i++)
         if (trig_at < 0 && v[i] != ((i == 0) ? base : v[i-1])) trig_at = i;
      j = trig_at;
      while (exp_q.size() < NBYTES) begin
         len = 0;
         while ((j + len) < v.size() && v[j+len] == v[j]) len++;
         for (int rem = len; rem > 0 && exp_q.size() < NBYTES; rem -= piece) begin
            piece = (rem > 31) ? 31 : rem;
            exp_q.push_back({v[j], 5'(piece)});
         end
         j += len;
      end
   endtask

   task automatic gen_random();
      int nruns, len;
      logic [2:0] v;
      stim_q.delete();
      nruns = int'($urandom_range(6, 2));
      for (int r = 0; r < nruns; r++) begin
         v = 3'($urandom_range(7, 0));
         if (r == 0 && v == base) v = base ^ 3'($urandom_range(7, 1));
         len = ($urandom_range(3, 0) == 0) ? int'($urandom_range(40, 25)) : int'($urandom_range(6, 1));
         for (int k = 0; k < len && stim_q.size() < 60; k++) stim_q.push_back(v);
      end
   endtask

   // Drive stim_q one value per clock while decoding the dump from TxD
   task automatic run_dump(input int trig_at);
      rx_q.delete();
      fork
         begin : drive
            int first = -1;
            logic [4:0] first_state = 5'd0;
            for (int k = 0; k < stim_q.size() + 10; k++) begin
               @(negedge clk);
               if (first < 0 && state_debug != 5'd0) begin
                  first       = k;
                  first_state = state_debug;
               end
               if (k < stim_q.size()) dataIn = stim_q[k];
            end
            // sampled at the edge after the change, synchronized, then the state register
            check("trig_latency", 32'(first), 32'(trig_at + 3));
            check("trig_state", 32'(first_state), 32'd1);
         end
         begin : recv
            int c, st, prev_st;
            logic [9:0] raw;
            bit ok = 1'b1;
            c = 0;
            while (state_debug != 5'd2 && c < CYC_LIMIT) begin @(negedge clk); c++; end
            check("load_state", 32'(state_debug), 32'd2);
            check("load_debug", 32'(dataOut_debug), 32'(exp_q[0]));
            prev_st = 0;
            for (int f = 0; f < NBYTES && ok; f++) begin
               c = 0;
               while (TxD !== 1'b0 && c < CYC_LIMIT) begin @(negedge clk); c++; end
               check("frame_start", 32'(TxD), 32'd0);
               if (TxD !== 1'b0) ok = 1'b0;
               st = cyc;
               if (f == 0) check("first_gap", 32'(c), 32'd1);
               else        check("frame_spacing", 32'(st - prev_st), 32'(FRAME_GAP));
               prev_st = st;
               for (int b = 0; b < 10 && ok; b++) begin
                  repeat ((b == 0) ? (BAUD_DIV / 2) : BAUD_DIV) @(negedge clk);
                  raw[b] = TxD;
               end
               check("frame_bits", 32'(raw), 32'({1'b1, exp_q[f], 1'b0}));
               check("frame_debug", 32'(dataOut_debug), 32'(exp_q[f]));
               rx_q.push_back(raw[8:1]);
            end
            c = 0;
            while (state_debug != 5'd0 && c < CYC_LIMIT) begin @(negedge clk); c++; end
            check("idle_after_dump", 32'(state_debug), 32'd0);
            check("txd_after_dump", 32'(TxD), 32'd1);
         end
      join
      base = stim_q[stim_q.size()-1];
   endtask

   initial begin
      int bad, c, t;
      dataIn = 3'b000;
      rst    = 1'b1;
      #10;
      rst    = 1'b0;
      check("reset_txd", 32'(TxD), 32'd1);
      check("reset_state", 32'(state_debug), 32'd0);
      check("reset_debug", 32'(dataOut_debug), 32'd0);
      base = 3'b000;

      // Quiet inputs must never trigger
      bad = 0;
      repeat (1000) begin
         @(negedge clk);
         if (TxD !== 1'b1 || state_debug !== 5'd0) bad++;
      end
      check("idle_hold", 32'(bad), 32'd0);

      // Directed encoding: 010x3, 001x5, 010x2, 111x4, then 000
      stim_q.delete();
      repeat (3) stim_q.push_back(3'b010);
      repeat (5) stim_q.push_back(3'b001);
      repeat (2) stim_q.push_back(3'b010);
      repeat (4) stim_q.push_back(3'b111);
      stim_q.push_back(3'b000);
      exp_q.delete();
`ifdef LA_TX_HEADER_EN
      exp_q.push_back(8'hA5);
      exp_q.push_back(8'h04);
`endif
      exp_q.push_back(8'h43);
      exp_q.push_back(8'h25);
      exp_q.push_back(8'h42);
      exp_q.push_back(8'hE4);
      run_dump(0);

      // Run saturation: 100 for 40 samples then 000 held
      stim_q.delete();
      repeat (40) stim_q.push_back(3'b100);
      stim_q.push_back(3'b000);
      exp_q.delete();
`ifdef LA_TX_HEADER_EN
      exp_q.push_back(8'hA5);
      exp_q.push_back(8'h04);
`endif
      exp_q.push_back(8'h9F);
      exp_q.push_back(8'h89);
      exp_q.push_back(8'h1F);
      exp_q.push_back(8'h1F);
      run_dump(0);

      // Reset while a data bit is low on the line
      repeat (5) begin @(negedge clk); dataIn = 3'b110; end
      @(negedge clk);
      dataIn = 3'b000;
      c = 0;
      while (!(state_debug == 5'd4 && TxD == 1'b0) && c < CYC_LIMIT) begin @(negedge clk); c++; end
      check("midframe_reached", 32'(state_debug), 32'd4);
      #10;
      rst = 1'b1;
      #1;
      check("midframe_rst_txd", 32'(TxD), 32'd1);
      check("midframe_rst_state", 32'(state_debug), 32'd0);
      check("midframe_rst_debug", 32'(dataOut_debug), 32'd0);
      repeat (2) @(negedge clk);
      rst  = 1'b0;
      base = 3'b000;
      bad  = 0;
      repeat (100) begin
         @(negedge clk);
         if (TxD !== 1'b1 || state_debug !== 5'd0) bad++;
      end
      check("post_reset_quiet", 32'(bad), 32'd0);
      gen_random();
      model(t);
      run_dump(t);

      // Re-arm: a dump ending with 001 held must not retrigger; 011 must
      stim_q.delete();
      repeat (3) stim_q.push_back(3'b101);
      repeat (2) stim_q.push_back(3'b001);
      model(t);
      run_dump(t);
      bad = 0;
      repeat (300) begin
         @(negedge clk);
         if (state_debug !== 5'd0) bad++;
      end
      check("rearm_no_trigger", 32'(bad), 32'd0);
      stim_q.delete();
      repeat (5) stim_q.push_back(3'b011);
      repeat (3) stim_q.push_back(3'b110);
      model(t);
      run_dump(t);
      check("rearm_first_value", 32'(rx_q[NHDR][7:5]), 32'd3);

      // Randomized captures against the run-length model
      for (int it = 0; it < 8; it++) begin
         gen_random();
         model(t);
         run_dump(t);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
